// File: rtl/shift_chain_sequencer.sv
// Serialises parallel words LSB-first into a DEPTH-stage shift chain, then flushes it.
// Optional macro SHIFT_PARITY_EN inserts a one-cycle even-parity bit between data and flush.
module shift_chain_sequencer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             negative_reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort,
  output logic             shift_en,
  output logic             shift_data,
  output logic             busy,
  output logic             frame_done,
  output logic             frame_aborted,
  output logic [15:0]      frame_count
);

  localparam int BW = $clog2(WIDTH) + 1;
  localparam int FW = $clog2(DEPTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
`ifdef SHIFT_PARITY_EN
    S_PARITY,
`endif
    S_FLUSH,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             par_q, par_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [FW-1:0]    flush_cnt_q, flush_cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             shift_en_q, shift_en_d;
  logic             shift_data_q, shift_data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic [15:0]      frame_count_q, frame_count_d;

  // Outputs are computed one cycle ahead so every output comes straight from a flop.
  always_comb begin
    state_d       = state_q;
    word_d        = word_q;
    par_d         = par_q;
    bit_cnt_d     = bit_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    in_ready_d    = 1'b0;
    shift_en_d    = 1'b0;
    shift_data_d  = 1'b0;
    done_d        = 1'b0;
    aborted_d     = 1'b0;
    frame_count_d = frame_count_q;
    case (state_q)
      S_IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          state_d      = S_SHIFT;
          word_d       = in_data >> 1;
          par_d        = ^in_data;
          bit_cnt_d    = BW'(1);
          shift_en_d   = 1'b1;
          shift_data_d = in_data[0];
          in_ready_d   = 1'b0;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (bit_cnt_q == BW'(WIDTH)) begin
          shift_en_d = 1'b1;
`ifdef SHIFT_PARITY_EN
          state_d      = S_PARITY;
          shift_data_d = par_q;
`else
          state_d     = S_FLUSH;
          flush_cnt_d = FW'(1);
`endif
        end else begin
          shift_en_d   = 1'b1;
          shift_data_d = word_q[0];
          word_d       = word_q >> 1;
          bit_cnt_d    = bit_cnt_q + BW'(1);
        end
      end
`ifdef SHIFT_PARITY_EN
      S_PARITY: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          state_d     = S_FLUSH;
          flush_cnt_d = FW'(1);
          shift_en_d  = 1'b1;
        end
      end
`endif
      S_FLUSH: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (flush_cnt_q == FW'(DEPTH)) begin
          state_d       = S_DONE;
          done_d        = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
        end else begin
          shift_en_d  = 1'b1;
          flush_cnt_d = flush_cnt_q + FW'(1);
        end
      end
      S_DONE: begin
        state_d    = S_IDLE;
        in_ready_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort is only honoured while the chain is being clocked; DONE always completes.
    if (abort && state_q != S_IDLE && state_q != S_DONE) begin
      in_ready_d  = 1'b1;
      aborted_d   = 1'b1;
      bit_cnt_d   = '0;
      flush_cnt_d = '0;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge negative_reset) begin
    if (!negative_reset) begin
      state_q       <= S_IDLE;
      word_q        <= '0;
      par_q         <= 1'b0;
      bit_cnt_q     <= '0;
      flush_cnt_q   <= '0;
      in_ready_q    <= 1'b1;
      shift_en_q    <= 1'b0;
      shift_data_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      word_q        <= word_d;
      par_q         <= par_d;
      bit_cnt_q     <= bit_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      in_ready_q    <= in_ready_d;
      shift_en_q    <= shift_en_d;
      shift_data_q  <= shift_data_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      aborted_q     <= aborted_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign shift_en      = shift_en_q;
  assign shift_data    = shift_data_q;
  assign busy          = busy_q;
  assign frame_done    = done_q;
  assign frame_aborted = aborted_q;
  assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_shift_chain_sequencer.sv
// Scoreboard bench: driver pushes the expected frame outcome, monitor pops on each end-of-frame pulse.
module tb_shift_chain_sequencer;
  localparam int W = 8;
  localparam int D = 4;
`ifdef SHIFT_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int L = W + P + D;

  logic          clock = 1'b0;
  logic          negative_reset;
  logic [W-1:0]  in_data;
  logic          in_valid, in_ready, abort;
  logic          shift_en, shift_data, busy, frame_done, frame_aborted;
  logic [15:0]   frame_count;

  shift_chain_sequencer #(.WIDTH(W), .DEPTH(D)) dut (
    .clock(clock), .negative_reset(negative_reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .abort(abort), .shift_en(shift_en), .shift_data(shift_data),
    .busy(busy), .frame_done(frame_done), .frame_aborted(frame_aborted), .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          start;
    int          end_c;
    bit          aborted;
    int          len;
    logic [63:0] bits;
    logic [15:0] count;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          ready_at;
  logic [15:0] m_cnt;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Model: a frame occupies L shifting cycles then a DONE cycle; an abort in
  // cycle N+a truncates the stream to a bits and pulses at N+a+1.
  task automatic run_frame(input logic [W-1:0] w, input int a, input bit hold);
    exp_t e;
    int   last;
    while (cyc < ready_at) @(negedge clock);
    in_valid = 1'b1;
    in_data  = w;
    abort    = 1'($urandom_range(0, 1));
    e.start  = cyc + 1;
    e.bits   = '0;
    for (int i = 0; i < W; i++) e.bits[i] = w[i];
    if (P == 1) e.bits[W] = ^w;
    e.aborted = (a > 0);
    if (a > 0) begin
      e.len    = a;
      e.end_c  = cyc + a + 1;
      e.count  = m_cnt;
      last     = a;
      ready_at = cyc + a + 1;
    end else begin
      e.len    = L;
      e.end_c  = cyc + L + 1;
      m_cnt    = m_cnt + 16'd1;
      e.count  = m_cnt;
      last     = L + 1;
      ready_at = cyc + L + 2;
    end
    sb.push_back(e);
    for (int t = 1; t <= last; t++) begin
      @(negedge clock);
      in_valid = hold;
      in_data  = W'($urandom);
      abort    = (a > 0) ? (t == a) : (t == L + 1 && $urandom_range(0, 1) == 1);
    end
    @(negedge clock);
    in_valid = 1'b0;
    abort    = 1'b0;
  endtask

  logic [63:0] got_bits;
  int          got_len = 0;
  int          first_c = 0;

  always @(negedge clock) begin
    exp_t        e;
    logic [63:0] m;
    if (!negative_reset) begin
      got_len  = 0;
      got_bits = '0;
    end else if (frame_done || frame_aborted) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pulse: done=%0b aborted=%0b with no frame expected (cycle %0d)",
                 frame_done, frame_aborted, cyc);
      end else begin
        e = sb.pop_front();
        m = (64'h1 << e.len) - 64'h1;
        chk("pulse_cycle", 64'(cyc), 64'(e.end_c));
        chk("pulse_is_abort", 64'(frame_aborted), 64'(e.aborted));
        chk("pulse_is_done", 64'(frame_done), 64'(!e.aborted));
        chk("stream_len", 64'(got_len), 64'(e.len));
        chk("first_shift_cycle", 64'(first_c), 64'(e.start));
        chk("stream_bits", got_bits & m, e.bits & m);
        chk("frame_count", 64'(frame_count), 64'(e.count));
        chk("in_ready_at_pulse", 64'(in_ready), 64'(e.aborted));
        chk("busy_at_pulse", 64'(busy), 64'(!e.aborted));
        chk("shift_en_at_pulse", 64'(shift_en), 64'h0);
      end
      got_len  = 0;
      got_bits = '0;
    end else if (shift_en) begin
      if (got_len == 0) first_c = cyc;
      if (got_len < 64) got_bits[got_len] = shift_data;
      got_len++;
    end else begin
      chk("data_zero_when_idle", 64'(shift_data), 64'h0);
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'h1);
    chk({tag, "_shift_en"}, 64'(shift_en), 64'h0);
    chk({tag, "_shift_data"}, 64'(shift_data), 64'h0);
    chk({tag, "_busy"}, 64'(busy), 64'h0);
    chk({tag, "_done"}, 64'(frame_done), 64'h0);
    chk({tag, "_aborted"}, 64'(frame_aborted), 64'h0);
    chk({tag, "_count"}, 64'(frame_count), 64'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d frames outstanding", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    negative_reset = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    abort    = 1'b0;
    m_cnt    = '0;
    ready_at = 0;
    repeat (2) @(negedge clock);
    chk_reset_vals("reset");
    negative_reset = 1'b1;
    ready_at = cyc;

    run_frame(8'hA5, 0, 1'b0);
    run_frame(8'hFF, 0, 1'b1);
    run_frame(8'h00, 0, 1'b0);
    run_frame(8'h3C, 5, 1'b0);
    run_frame(8'h07, 0, 1'b0);
    run_frame(8'h03, 0, 1'b0);
    run_frame(8'h81, 1, 1'b1);
    run_frame(8'h55, W + 1, 1'b0);
    run_frame(8'hC3, L, 1'b0);

    // Asynchronous reset in the middle of the flush, away from any edge.
    while (cyc < ready_at) @(negedge clock);
    in_valid = 1'b1;
    in_data  = 8'h5A;
    n0 = cyc;
    @(negedge clock);
    in_valid = 1'b0;
    while (cyc < n0 + 10) @(negedge clock);
    #2 negative_reset = 1'b0;
    #1 chk_reset_vals("midframe_reset");
    repeat (2) @(negedge clock);
    #2 negative_reset = 1'b1;
    m_cnt = '0;
    @(negedge clock);
    ready_at = cyc;
    run_frame(8'h01, 0, 1'b0);

    // Counter wrap: preload just below the top.
    while (cyc < ready_at) @(negedge clock);
    force dut.frame_count_q = 16'hFFFE;
    #1 release dut.frame_count_q;
    m_cnt = 16'hFFFE;
    run_frame(W'($urandom), 0, 1'b0);
    run_frame(W'($urandom), 0, 1'b0);

    for (int k = 0; k < 150; k++)
      run_frame(W'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, L)) : 0,
                1'($urandom_range(0, 1)));

    for (int k = 0; k < 200 && sb.size() > 0; k++) @(negedge clock);
    chk("scoreboard_drained", 64'(sb.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/shift_chain_sequencer.md
Name: shift_chain_sequencer

Overview:
Sequencer for the serial shift-register chain. It accepts parallel words over a valid/ready handshake and serialises each word LSB-first into the chain input. It then clocks the chain for DEPTH extra cycles so the last bit reaches the chain output, and signals frame completion. It sits between a parallel producer and the DEPTH-stage chain, and it owns the chain's shift enable.

Parameters:
WIDTH, 8, data bits per frame (2..32)
DEPTH, 4, number of stages in the driven chain; flush length in cycles (1..16)

Ports:
clock  input  1  system clock, rising edge
negative_reset  input  1  asynchronous active-low reset
in_data  input  WIDTH  parallel word to serialise
in_valid  input  1  in_data valid
in_ready  output  1  block can accept a word
abort  input  1  synchronous abort of the current frame
shift_en  output  1  chain shift enable
shift_data  output  1  serial bit into chain stage 0
busy  output  1  frame in progress (not IDLE)
frame_done  output  1  one-cycle pulse at end of a completed frame
frame_aborted  output  1  one-cycle pulse when a frame is aborted
frame_count  output  16  completed-frame counter

Behaviour:
- Reset (negative_reset low, async): state=IDLE; in_ready=1; shift_en=0; shift_data=0; busy=0; frame_done=0; frame_aborted=0; frame_count=0; internal shift and bit counters=0.
- All outputs are registered.
- States: IDLE, SHIFT, FLUSH, DONE (PARITY added only with the optional feature).
- IDLE: in_ready=1. On in_valid&&in_ready at edge N: latch in_data, bit_cnt=0, go to SHIFT. in_ready=0 from N+1.
- SHIFT: shift_en=1, shift_data=current LSB of latched word. Word shifts right one bit per cycle.
- SHIFT exit: after WIDTH cycles go to FLUSH. Data bit k is presented in cycle N+1+k.
- FLUSH: shift_en=1, shift_data=0 for exactly DEPTH cycles, then go to DONE.
- DONE: lasts one cycle. shift_en=0, frame_done=1, frame_count increments. Next state IDLE.
- Handshake is re-armed after DONE: in_ready=1 again at N+WIDTH+DEPTH+2. No back-to-back overlap.
- Timing summary (accept at N): shift_en high N+1..N+WIDTH+DEPTH; frame_done at N+WIDTH+DEPTH+1.
- in_valid outside IDLE is ignored. A word is not captured unless in_ready=1.
- abort in SHIFT or FLUSH: next cycle shift_en=0, shift_data=0, frame_aborted=1 for one cycle, state=IDLE.
  - frame_count is unchanged and frame_done is not asserted.
  - in_ready=1 in that same next cycle.
- abort in IDLE or DONE: no effect. DONE completes normally.
- abort and in_valid together in IDLE: the word is accepted and abort is ignored.
- frame_count wraps 16'hFFFF -> 16'h0000 with no flag.
- Reset mid-frame: everything returns to reset values immediately (async). The partial frame is discarded and no pulse is generated.
- Counters are sized to $clog2 of their maximum count plus 1. There is no overflow inside the legal parameter range.

Optional Feature:
Macro SHIFT_PARITY_EN.
- Defined: a PARITY state is inserted between SHIFT and FLUSH.
  - It lasts one cycle with shift_en=1 and shift_data = even parity (XOR) of the latched word.
  - frame_done moves one cycle later, to N+WIDTH+DEPTH+2.
  - An abort in PARITY behaves as an abort in SHIFT.
- Not defined: no PARITY state, and the timing is as above.

Test Plan:
- Test 1 (WIDTH=8, DEPTH=4): reset, then in_data=8'hA5 with in_valid at cycle 0.
  - shift_data over cycles 1..8 = 1,0,1,0,0,1,0,1.
  - shift_en high over cycles 1..12 with shift_data=0 in 9..12.
  - frame_done=1 at cycle 13, frame_count=1, in_ready=1 at cycle 14.
- Test 2: hold in_valid high with 8'hFF then 8'h00.
  - The second word is accepted only at cycle 14.
  - Its bits appear over cycles 15..22, all zero. frame_count=2 after its frame_done.
- Test 3: abort at cycle 5 of an 8'h3C frame.
  - Cycle 6: shift_en=0, frame_aborted=1, in_ready=1.
  - frame_done never asserts and frame_count is unchanged.
- Test 4: pull negative_reset low mid-FLUSH (cycle 10), off the clock edge.
  - All outputs take reset values immediately, with no frame_done.
  - After release, a new 8'h01 frame runs normally.
- Test 5: preload frame_count near 16'hFFFF by completing frames (or force it).
  - The completion after 16'hFFFF yields 16'h0000.
- Test 6 (SHIFT_PARITY_EN defined): in_data=8'h07.
  - Cycle 9 carries parity bit 1, flush runs over cycles 10..13, frame_done at cycle 14.
  - With 8'h03 the parity bit is 0.
